// File: rtl/decode_unit.sv
`default_nettype none
//==============================================================================
// Module   : decode_unit
// Desc     : Instruction decode stage with load-use interlock and flush squash.
//            Optional illegal-opcode trap enabled by defining ILLEGAL_INST_TRAP_EN.
// Revision : 1.0
//==============================================================================

package decode_unit_pkg;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] fetched_inst;
    logic        do_not_execute;
  } if_id_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        illegal;
    logic        do_not_execute;
  } id_ex_t;

  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_REG    = 7'b0110011;

endpackage

module decode_unit
  import decode_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  if_id_t      if_id_r,
  input  logic        flush,
  output logic [4:0]  rf_rd_addr1,
  output logic [4:0]  rf_rd_addr2,
  input  logic [31:0] rf_rd_data1,
  input  logic [31:0] rf_rd_data2,
  output logic        stall,
  output logic        illegal_seen,
  output id_ex_t      id_ex_r
);

  logic [31:0] w_inst;
  logic [6:0]  w_opcode;
  logic [31:0] w_imm;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_hazard;
  logic        w_illegal;
  id_ex_t      w_next;
  id_ex_t      r_id_ex;

  assign w_inst      = if_id_r.fetched_inst;
  assign w_opcode    = w_inst[6:0];
  assign rf_rd_addr1 = w_inst[19:15];
  assign rf_rd_addr2 = w_inst[24:20];

  always_comb begin
    w_imm = 32'd0;
    case (w_opcode)
      C_OP_LOAD, C_OP_IMM, C_OP_JALR: w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
      C_OP_STORE:  w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      C_OP_BRANCH: w_imm = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      C_OP_LUI, C_OP_AUIPC: w_imm = {w_inst[31:12], 12'd0};
      C_OP_JAL:    w_imm = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      default:     w_imm = 32'd0;
    endcase
  end

  assign w_rs1_used = !((w_opcode == C_OP_LUI) || (w_opcode == C_OP_AUIPC) || (w_opcode == C_OP_JAL));
  assign w_rs2_used = (w_opcode == C_OP_REG) || (w_opcode == C_OP_STORE) || (w_opcode == C_OP_BRANCH);

  // Load in execute whose destination feeds a source of the instruction now in decode
  assign w_hazard = !r_id_ex.do_not_execute && (r_id_ex.opcode == C_OP_LOAD) &&
                    (r_id_ex.rd != 5'd0) && !if_id_r.do_not_execute &&
                    ((w_rs1_used && (r_id_ex.rd == w_inst[19:15])) ||
                     (w_rs2_used && (r_id_ex.rd == w_inst[24:20])));

  assign stall = w_hazard && !flush;

`ifdef ILLEGAL_INST_TRAP_EN
  logic w_known;
  logic r_illegal_seen;

  assign w_known = (w_opcode == C_OP_LUI)    || (w_opcode == C_OP_AUIPC) ||
                   (w_opcode == C_OP_JAL)    || (w_opcode == C_OP_JALR)  ||
                   (w_opcode == C_OP_BRANCH) || (w_opcode == C_OP_LOAD)  ||
                   (w_opcode == C_OP_STORE)  || (w_opcode == C_OP_IMM)   ||
                   (w_opcode == C_OP_REG);
  assign w_illegal = !if_id_r.do_not_execute && !w_known;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal_seen <= 1'b0;
    end else if (w_illegal) begin
      r_illegal_seen <= 1'b1;
    end
  end

  assign illegal_seen = r_illegal_seen;
`else
  assign w_illegal    = 1'b0;
  assign illegal_seen = 1'b0;
`endif

  always_comb begin
    w_next                = '0;
    w_next.pc             = if_id_r.pc;
    w_next.opcode         = w_opcode;
    w_next.rd             = w_inst[11:7];
    w_next.rs1            = w_inst[19:15];
    w_next.rs2            = w_inst[24:20];
    w_next.funct3         = w_inst[14:12];
    w_next.funct7         = w_inst[31:25];
    w_next.imm            = w_imm;
    w_next.rs1_val        = rf_rd_data1;
    w_next.rs2_val        = rf_rd_data2;
    w_next.illegal        = w_illegal;
    w_next.do_not_execute = if_id_r.do_not_execute || flush || stall || w_illegal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id_ex                <= '0;
      r_id_ex.do_not_execute <= 1'b1;
    end else begin
      r_id_ex <= w_next;
    end
  end

  assign id_ex_r = r_id_ex;

endmodule

`default_nettype wire

// File: tb/tb_decode_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_decode_unit
// Desc     : Scoreboard bench for decode_unit; honours ILLEGAL_INST_TRAP_EN.
// Revision : 1.0
//==============================================================================

module tb_decode_unit;
  import decode_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  if_id_t      if_id_r;
  logic        flush;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        stall;
  logic        illegal_seen;
  id_ex_t      id_ex_r;

  decode_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_id_r      (if_id_r),
    .flush        (flush),
    .rf_rd_addr1  (rf_rd_addr1),
    .rf_rd_addr2  (rf_rd_addr2),
    .rf_rd_data1  (rf_rd_data1),
    .rf_rd_data2  (rf_rd_data2),
    .stall        (stall),
    .illegal_seen (illegal_seen),
    .id_ex_r      (id_ex_r)
  );

  always #5 clk = ~clk;

  // Register file stand-in: contents are a fixed function of the address
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return 32'hCAFE_0000 + {27'd0, a};
  endfunction
  assign rf_rd_data1 = rf_val(rf_rd_addr1);
  assign rf_rd_data2 = rf_val(rf_rd_addr2);

  int     n_tests = 0;
  int     n_fail  = 0;
  id_ex_t sb[$];
  id_ex_t m_prev;
  id_ex_t rst_val;
  logic   m_seen;
  logic   obs_stall;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input if_id_t f, input logic fl, input id_ex_t p,
                                output id_ex_t e, output logic st);
    logic [31:0] i;
    logic [6:0]  op;
    logic [31:0] imm;
    logic        use1, use2, known, ill;
    i  = f.fetched_inst;
    op = i[6:0];
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: imm = {{20{i[31]}}, i[31:20]};
      7'b0100011: imm = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {i[31:12], 12'd0};
      7'b1101111: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    use1  = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    use2  = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    known = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                       7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    st = !fl && !f.do_not_execute && !p.do_not_execute && (p.opcode == 7'b0000011) &&
         (p.rd != 5'd0) && ((use1 && p.rd == i[19:15]) || (use2 && p.rd == i[24:20]));
`ifdef ILLEGAL_INST_TRAP_EN
    ill = !f.do_not_execute && !known;
`else
    ill = 1'b0;
`endif
    e.pc             = f.pc;
    e.opcode         = op;
    e.rd             = i[11:7];
    e.rs1            = i[19:15];
    e.rs2            = i[24:20];
    e.funct3         = i[14:12];
    e.funct7         = i[31:25];
    e.imm            = imm;
    e.rs1_val        = rf_val(i[19:15]);
    e.rs2_val        = rf_val(i[24:20]);
    e.illegal        = ill;
    e.do_not_execute = f.do_not_execute | fl | st | ill;
  endfunction

  // Drive one decode cycle; expected result is queued, then compared after the edge
  task automatic step(input logic [15:0] pc, input logic [31:0] inst,
                      input logic dne, input logic fl);
    id_ex_t e;
    id_ex_t q;
    logic   st;
    if_id_r = '{pc: pc, fetched_inst: inst, do_not_execute: dne};
    flush   = fl;
    #1;
    model(if_id_r, fl, m_prev, e, st);
    obs_stall = stall;
    check_val("stall", stall, st);
    check_val("rf_addr1", rf_rd_addr1, inst[19:15]);
    check_val("rf_addr2", rf_rd_addr2, inst[24:20]);
    sb.push_back(e);
    m_prev = e;
    m_seen = m_seen | e.illegal;
    @(posedge clk);
    #1;
    q = sb.pop_front();
    check_val("id_ex", id_ex_r, q);
    check_val("illegal_seen", illegal_seen, m_seen);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_val("rst_id_ex", id_ex_r, rst_val);
    check_val("rst_stall", stall, 1'b0);
    check_val("rst_seen", illegal_seen, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_prev  = rst_val;
    m_seen  = 1'b0;
  endtask

  localparam logic [31:0] C_ADDI   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] C_BEQ    = 32'hFE00_0EE3; // beq x0,x0,-4
  localparam logic [31:0] C_LW2    = 32'h0000_A103; // lw x2,0(x1)
  localparam logic [31:0] C_ADD    = 32'h0021_01B3; // add x3,x2,x2
  localparam logic [31:0] C_LW4    = 32'h0001_2203; // lw x4,0(x2)
  localparam logic [31:0] C_LW5    = 32'h0002_2283; // lw x5,0(x4)
  localparam logic [31:0] C_LW0    = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] C_ADD00  = 32'h0000_01B3; // add x3,x0,x0
  localparam logic [31:0] C_LUI    = 32'h0001_01B7; // lui x3,0x10 (rs1 field = 2)
  localparam logic [31:0] C_SW     = 32'h0020_A423; // sw x2,8(x1)
  localparam logic [31:0] C_JAL    = 32'hFF9F_F0EF; // jal x1,-8
  localparam logic [31:0] C_ILL    = 32'h0000_007F;
  localparam logic [31:0] C_NOP    = 32'h0000_0013;

  logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

  initial begin
    rst_val                = '0;
    rst_val.do_not_execute = 1'b1;
    m_prev  = rst_val;
    m_seen  = 1'b0;
    if_id_r = '{pc: 16'h0, fetched_inst: C_NOP, do_not_execute: 1'b0};
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // ALU and immediate forms
    step(16'h0000, C_ADDI, 1'b0, 1'b0);
    check_val("addi_op", id_ex_r.opcode, 7'b0010011);
    check_val("addi_rd", id_ex_r.rd, 5'd1);
    check_val("addi_imm", id_ex_r.imm, 32'd5);
    check_val("addi_dne", id_ex_r.do_not_execute, 1'b0);
    step(16'h0004, C_BEQ, 1'b0, 1'b0);
    check_val("beq_imm", id_ex_r.imm, 32'hFFFF_FFFC);
    step(16'h0008, C_JAL, 1'b0, 1'b0);
    check_val("jal_imm", id_ex_r.imm, 32'hFFFF_FFF8);

    // Load-use: one stall, one bubble, then issue
    step(16'h0010, C_LW2, 1'b0, 1'b0);
    step(16'h0014, C_ADD, 1'b0, 1'b0);
    check_val("lu_stall", obs_stall, 1'b1);
    check_val("lu_bubble", id_ex_r.do_not_execute, 1'b1);
    step(16'h0014, C_ADD, 1'b0, 1'b0);
    check_val("lu_nostall", obs_stall, 1'b0);
    check_val("lu_issue", id_ex_r.do_not_execute, 1'b0);

    // Flush overrides stall
    step(16'h0020, C_LW2, 1'b0, 1'b0);
    step(16'h0024, C_ADD, 1'b0, 1'b1);
    check_val("fl_stall", obs_stall, 1'b0);
    check_val("fl_dne", id_ex_r.do_not_execute, 1'b1);

    // Back-to-back loads, rd=0, bubble input, U-type and store sources
    step(16'h0030, C_LW2, 1'b0, 1'b0);
    step(16'h0034, C_LW4, 1'b0, 1'b0);
    step(16'h0034, C_LW4, 1'b0, 1'b0);
    step(16'h0038, C_LW5, 1'b0, 1'b0);
    check_val("b2b_stall", obs_stall, 1'b1);
    step(16'h0038, C_LW5, 1'b0, 1'b0);
    step(16'h0040, C_LW0, 1'b0, 1'b0);
    step(16'h0044, C_ADD00, 1'b0, 1'b0);
    check_val("rd0_stall", obs_stall, 1'b0);
    step(16'h0048, C_LW2, 1'b0, 1'b0);
    step(16'h004C, C_ADD, 1'b1, 1'b0);
    check_val("bub_dne", id_ex_r.do_not_execute, 1'b1);
    step(16'h0050, C_LW2, 1'b0, 1'b0);
    step(16'h0054, C_LUI, 1'b0, 1'b0);
    check_val("lui_imm", id_ex_r.imm, 32'h0001_0000);
    step(16'h0058, C_LW2, 1'b0, 1'b0);
    step(16'h005C, C_SW, 1'b0, 1'b0);
    check_val("sw_stall", obs_stall, 1'b1);
    step(16'h005C, C_SW, 1'b0, 1'b0);
    check_val("sw_imm", id_ex_r.imm, 32'd8);

    // Reset while a stall is pending
    step(16'h0060, C_LW2, 1'b0, 1'b0);
    if_id_r = '{pc: 16'h0064, fetched_inst: C_ADD, do_not_execute: 1'b0};
    flush   = 1'b0;
    #1;
    check_val("mid_stall_pre", stall, 1'b1);
    apply_reset();
    step(16'h0064, C_ADD, 1'b0, 1'b0);
    check_val("post_rst_dne", id_ex_r.do_not_execute, 1'b0);

    // Unknown opcode
    step(16'h0070, C_ILL, 1'b0, 1'b0);
`ifdef ILLEGAL_INST_TRAP_EN
    check_val("ill_flag", id_ex_r.illegal, 1'b1);
    check_val("ill_dne", id_ex_r.do_not_execute, 1'b1);
    step(16'h0074, C_NOP, 1'b0, 1'b0);
    check_val("ill_sticky", illegal_seen, 1'b1);
    apply_reset();
    check_val("ill_cleared", illegal_seen, 1'b0);
`else
    check_val("ill_flag", id_ex_r.illegal, 1'b0);
    check_val("ill_imm", id_ex_r.imm, 32'd0);
    check_val("ill_dne", id_ex_r.do_not_execute, 1'b0);
    check_val("ill_seen", illegal_seen, 1'b0);
`endif

    // Randomised mix over a small register window to provoke hazards
    for (int k = 0; k < 40; k++) begin
      logic [31:0] r;
      r        = $urandom;
      r[6:0]   = ops[$urandom_range(0, 9)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(16'(k * 4), r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
